hwce_tcdm_responder: RTL and testbench



---
 rtl/hwce_tcdm_resp_pkg.sv | 43 ++++
 rtl/hwce_tcdm_rr_arbiter.sv | 44 ++++
 rtl/hwce_tcdm_responder.sv | 167 ++++++++++++++++
 tb/tb_hwce_tcdm_responder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hwce_tcdm_resp_pkg.sv
// Shared types and constants for the HWCE TCDM responder.
package hwce_tcdm_resp_pkg;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned BE_W           = DATA_W / 8;
  localparam int unsigned N_BANK_DEF     = 4;
  localparam int unsigned BANK_WORDS_DEF = 1024;

  // Bank-select and row-select widths for the default geometry
  localparam int unsigned BANK_BITS = $clog2(N_BANK_DEF);
  localparam int unsigned ROW_BITS  = $clog2(BANK_WORDS_DEF);

  // Read data returned for any access outside the mapped window
  localparam logic [DATA_W-1:0] ERR_RDATA = 32'hDEAD_BEEF;

  // One initiator request as seen on a LINT port (is_read: 1=read, 0=write)
  typedef struct packed {
    logic [ADDR_W-1:0] add;
    logic              is_read;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] data;
  } tcdm_req_t;

  // One response slot per port, registered one cycle after the grant
  typedef struct packed {
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
  } tcdm_resp_t;

  // Merge new bytes into an old word under a byte-enable mask
  function automatic logic [DATA_W-1:0] be_merge(input logic [DATA_W-1:0] oldWord,
                                                 input logic [DATA_W-1:0] newWord,
                                                 input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] res;
    res = oldWord;
    for (int i = 0; i < int'(BE_W); i++) begin
      if (be[i]) res[i*8 +: 8] = newWord[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/hwce_tcdm_rr_arbiter.sv
// Round-robin arbiter for one bank: one-hot grant, winner index and a pointer
// that advances to winner+1 only when something is granted.
module hwce_tcdm_rr_arbiter #(
  parameter int unsigned N_REQ = 3,
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] win_idx_o,
  output logic             win_valid_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  int unsigned      cand;

  // Scan requests starting at the pointer; first requester wins, pointer follows it
  always_comb begin
    gnt_o       = '0;
    win_idx_o   = '0;
    win_valid_o = 1'b0;
    cand        = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = (32'(ptr_q) + i) % N_REQ;
      if (!win_valid_o && req_i[cand]) begin
        win_valid_o = 1'b1;
        win_idx_o   = IDX_W'(cand);
        gnt_o[cand] = 1'b1;
      end
    end
    ptr_d = ptr_q;
    if (win_valid_o) begin
      ptr_d = (32'(win_idx_o) == N_REQ - 1) ? '0 : win_idx_o + 1'b1;
    end
  end

  // Pointer register; restarts at port 0 on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/hwce_tcdm_responder.sv
// Multi-port TCDM LINT responder: word-interleaved banked SRAM model with
// per-bank round-robin arbitration, single-cycle responses and a conflict counter.
// The address port width is expected to match the package address width.
module hwce_tcdm_responder
  import hwce_tcdm_resp_pkg::*;
#(
  parameter int unsigned N_PORT     = 3,
  parameter int unsigned N_BANK     = N_BANK_DEF,
  parameter int unsigned BANK_WORDS = BANK_WORDS_DEF,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_PORT-1:0]            tcdm_req_i,
  output logic [N_PORT-1:0]            tcdm_gnt_o,
  input  logic [N_PORT*ADDR_WIDTH-1:0] tcdm_add_i,
  input  logic [N_PORT-1:0]            tcdm_type_i,
  input  logic [N_PORT*BE_WIDTH-1:0]   tcdm_be_i,
  input  logic [N_PORT*DATA_WIDTH-1:0] tcdm_data_i,
  output logic [N_PORT*DATA_WIDTH-1:0] tcdm_r_data_o,
  output logic [N_PORT-1:0]            tcdm_r_valid_o,
  output logic [31:0]                  conflict_cnt_o,
  output logic                         addr_err_o
);

  localparam int unsigned BSEL_W = $clog2(N_BANK);
  localparam int unsigned RSEL_W = $clog2(BANK_WORDS);
  localparam int unsigned PTR_W  = (N_PORT > 1) ? $clog2(N_PORT) : 1;
  localparam logic [ADDR_WIDTH-1:0] WINDOW_BYTES = ADDR_WIDTH'(N_BANK * BANK_WORDS * 4);

  tcdm_req_t             reqPort [N_PORT];
  logic [ADDR_WIDTH-1:0] offset  [N_PORT];
  logic [BSEL_W-1:0]     bankSel [N_PORT];
  logic [RSEL_W-1:0]     rowSel  [N_PORT];
  logic [N_PORT-1:0]     inWin;

  logic [N_PORT-1:0]     bankReq [N_BANK];
  logic [N_PORT-1:0]     bankGnt [N_BANK];
  logic [PTR_W-1:0]      bankWin [N_BANK];
  logic                  bankAny [N_BANK];
  logic [N_PORT-1:0]     gntAll;

  logic [DATA_WIDTH-1:0] mem [N_BANK][BANK_WORDS];

  tcdm_resp_t            resp_q [N_PORT];
  tcdm_resp_t            resp_d [N_PORT];
  logic [31:0]           conflictCnt_q, conflictCnt_d;
  logic                  addrErr_q, addrErr_d;
  logic [31:0]           deniedCnt;
  logic [32:0]           cntSum;

  // Unpack the flat ports and decode window, bank and row per port
  always_comb begin
    for (int p = 0; p < N_PORT; p++) begin
      reqPort[p].add     = tcdm_add_i[p*ADDR_WIDTH +: ADDR_WIDTH];
      reqPort[p].is_read = tcdm_type_i[p];
      reqPort[p].be      = tcdm_be_i[p*BE_WIDTH +: BE_WIDTH];
      reqPort[p].data    = tcdm_data_i[p*DATA_WIDTH +: DATA_WIDTH];
      offset[p]          = reqPort[p].add - BASE_ADDR;
      inWin[p]           = offset[p] < WINDOW_BYTES;
      bankSel[p]         = offset[p][2 +: BSEL_W];
      rowSel[p]          = offset[p][2+BSEL_W +: RSEL_W];
    end
  end

  // Route each in-window request to the arbiter of the bank it addresses
  always_comb begin
    for (int b = 0; b < N_BANK; b++) begin
      for (int p = 0; p < N_PORT; p++) begin
        bankReq[b][p] = tcdm_req_i[p] & inWin[p] & (bankSel[p] == BSEL_W'(b));
      end
    end
  end

  for (genvar b = 0; b < N_BANK; b++) begin : g_bank_arb
    hwce_tcdm_rr_arbiter #(.N_REQ(N_PORT)) u_arb (
      .clk         (clk),
      .rst         (rst),
      .req_i       (bankReq[b]),
      .gnt_o       (bankGnt[b]),
      .win_idx_o   (bankWin[b]),
      .win_valid_o (bankAny[b])
    );
  end

  // Combine bank grants with the arbitration-free out-of-window grants; none in reset
  always_comb begin
    gntAll = '0;
    for (int p = 0; p < N_PORT; p++) begin
      if (tcdm_req_i[p] && !inWin[p]) gntAll[p] = 1'b1;
    end
    for (int b = 0; b < N_BANK; b++) begin
      gntAll = gntAll | bankGnt[b];
    end
    if (rst) gntAll = '0;
    tcdm_gnt_o = gntAll;
  end

  // Bank storage: the single winner of each bank may write; contents survive reset
  always_ff @(posedge clk) begin
    for (int b = 0; b < N_BANK; b++) begin
      if (!rst && bankAny[b] && !reqPort[bankWin[b]].is_read) begin
        mem[b][rowSel[bankWin[b]]] <= be_merge(mem[b][rowSel[bankWin[b]]],
                                               reqPort[bankWin[b]].data,
                                               reqPort[bankWin[b]].be);
      end
    end
  end

  // Next response per port: old word for reads, error pattern off-window, zero for writes
  always_comb begin
    for (int p = 0; p < N_PORT; p++) begin
      resp_d[p].r_valid = gntAll[p];
      resp_d[p].r_data  = resp_q[p].r_data;
      if (gntAll[p]) begin
        if (!reqPort[p].is_read)  resp_d[p].r_data = '0;
        else if (!inWin[p])       resp_d[p].r_data = ERR_RDATA;
        else                      resp_d[p].r_data = mem[bankSel[p]][rowSel[p]];
      end
    end
  end

  // Response registers; reset discards anything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < N_PORT; p++) resp_q[p] <= '0;
    end else begin
      for (int p = 0; p < N_PORT; p++) resp_q[p] <= resp_d[p];
    end
  end

  // Saturating count of denied request-cycles and sticky out-of-window flag
  always_comb begin
    deniedCnt = '0;
    for (int p = 0; p < N_PORT; p++) begin
      deniedCnt = deniedCnt + 32'(tcdm_req_i[p] & ~gntAll[p]);
    end
    cntSum        = {1'b0, conflictCnt_q} + {1'b0, deniedCnt};
    conflictCnt_d = cntSum[32] ? '1 : cntSum[31:0];
    addrErr_d     = addrErr_q | (|(gntAll & ~inWin));
  end

  // Status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflictCnt_q <= '0;
      addrErr_q     <= 1'b0;
    end else begin
      conflictCnt_q <= conflictCnt_d;
      addrErr_q     <= addrErr_d;
    end
  end

  // Flatten registered responses onto the output ports
  always_comb begin
    for (int p = 0; p < N_PORT; p++) begin
      tcdm_r_valid_o[p]                       = resp_q[p].r_valid;
      tcdm_r_data_o[p*DATA_WIDTH +: DATA_WIDTH] = resp_q[p].r_data;
    end
    conflict_cnt_o = conflictCnt_q;
    addr_err_o     = addrErr_q;
  end

endmodule

// File: tb/tb_hwce_tcdm_responder.sv
// Self-checking bench for hwce_tcdm_responder: table of per-cycle vectors with
// hand-derived grants, a memory model feeding a response scoreboard, and a
// hand-written reset-in-flight sequence.
module tb_hwce_tcdm_responder;

  localparam logic [31:0] B = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [2:0]  gnt;
  logic [95:0] add;
  logic [2:0]  typ;
  logic [11:0] be;
  logic [95:0] wdata;
  logic [95:0] rdata;
  logic [2:0]  rvalid;
  logic [31:0] cnt;
  logic        err;

  typedef struct packed {
    logic [2:0]       req;
    logic [2:0][31:0] add;
    logic [2:0]       typ;
    logic [2:0][3:0]  be;
    logic [2:0][31:0] data;
    logic [2:0]       expGnt;
  } vec_t;

  typedef struct {
    int          port;
    logic [31:0] data;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  logic [31:0] mMem [int];
  logic [31:0] lastData [3];
  logic [31:0] mCnt;
  logic        mErr;
  int          compCount = 0;
  int          failCount = 0;

  hwce_tcdm_responder dut (
    .clk            (clk),
    .rst            (rst),
    .tcdm_req_i     (req),
    .tcdm_gnt_o     (gnt),
    .tcdm_add_i     (add),
    .tcdm_type_i    (typ),
    .tcdm_be_i      (be),
    .tcdm_data_i    (wdata),
    .tcdm_r_data_o  (rdata),
    .tcdm_r_valid_o (rvalid),
    .conflict_cnt_o (cnt),
    .addr_err_o     (err)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t addPort(input vec_t v, input int p, input logic [31:0] a,
                                   input logic t, input logic [3:0] e, input logic [31:0] d);
    vec_t r;
    r         = v;
    r.req[p]  = 1'b1;
    r.add[p]  = a;
    r.typ[p]  = t;
    r.be[p]   = e;
    r.data[p] = d;
    return r;
  endfunction

  function automatic vec_t one(input int p, input logic [31:0] a, input logic t,
                               input logic [3:0] e, input logic [31:0] d);
    vec_t r;
    r = '0;
    r = addPort(r, p, a, t, e, d);
    r.expGnt[p] = 1'b1;
    return r;
  endfunction

  task automatic checkOutput(input string nm, input logic [95:0] got, input logic [95:0] exp);
    compCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Pop this cycle's expected responses and compare valid, data, counter and flag
  task automatic checkResponses(input string nm);
    logic [2:0]  expValid;
    logic [31:0] expData [3];
    exp_t        e;
    expValid = '0;
    for (int p = 0; p < 3; p++) expData[p] = lastData[p];
    while (sb.size() > 0) begin
      e = sb.pop_front();
      expValid[e.port] = 1'b1;
      expData[e.port]  = e.data;
    end
    checkOutput({nm, "/rvalid"}, 96'(rvalid), 96'(expValid));
    for (int p = 0; p < 3; p++) begin
      checkOutput($sformatf("%s/rdata%0d", nm, p), 96'(rdata[p*32 +: 32]), 96'(expData[p]));
      lastData[p] = expData[p];
    end
    checkOutput({nm, "/cnt"}, 96'(cnt), 96'(mCnt));
    checkOutput({nm, "/err"}, 96'(err), 96'(mErr));
  endtask

  // Drive one vector just after a rising edge, check grants mid-cycle, update the
  // model and scoreboard, then check responses just after the next rising edge
  task automatic applyStimulus(input vec_t v, input string nm);
    logic [31:0] off;
    int          w;
    for (int p = 0; p < 3; p++) begin
      req[p]            = v.req[p];
      add[p*32 +: 32]   = v.add[p];
      typ[p]            = v.typ[p];
      be[p*4 +: 4]      = v.be[p];
      wdata[p*32 +: 32] = v.data[p];
    end
    @(negedge clk);
    checkOutput({nm, "/gnt"}, 96'(gnt), 96'(v.expGnt));
    for (int p = 0; p < 3; p++) begin
      if (v.req[p] && v.expGnt[p]) begin
        off = v.add[p] - B;
        w   = int'(off >> 2);
        if (!v.typ[p])          sb.push_back('{p, 32'h0});
        else if (off >= 32'h4000) sb.push_back('{p, 32'hDEAD_BEEF});
        else                    sb.push_back('{p, mMem.exists(w) ? mMem[w] : 32'h0});
        if (off >= 32'h4000) mErr = 1'b1;
      end
    end
    for (int p = 0; p < 3; p++) begin
      if (v.req[p] && v.expGnt[p] && !v.typ[p]) begin
        off = v.add[p] - B;
        w   = int'(off >> 2);
        if (off < 32'h4000) begin
          if (!mMem.exists(w)) mMem[w] = 32'h0;
          for (int k = 0; k < 4; k++) begin
            if (v.be[p][k]) mMem[w][k*8 +: 8] = v.data[p][k*8 +: 8];
          end
        end
      end
    end
    mCnt = mCnt + 32'($countones(v.req & ~v.expGnt));
    @(posedge clk);
    #1;
    checkResponses(nm);
  endtask

  // Main sequence: reset checks, vector table, then reset with a read in flight
  initial begin
    vec_t v;
    mCnt = '0;
    mErr = 1'b0;
    for (int p = 0; p < 3; p++) lastData[p] = '0;

    rst   = 1'b1;
    req   = 3'b111;
    add   = {B, B, B};
    typ   = 3'b111;
    be    = '1;
    wdata = '0;
    #2;
    checkOutput("reset/gnt", 96'(gnt), 96'(0));
    checkOutput("reset/rvalid", 96'(rvalid), 96'(0));
    checkOutput("reset/rdata", rdata, 96'(0));
    checkOutput("reset/cnt", 96'(cnt), 96'(0));
    checkOutput("reset/err", 96'(err), 96'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = '0;

    vecs.push_back(one(0, B + 32'h10, 1'b0, 4'hF, 32'hCAFE_F00D));
    vecs.push_back(one(0, B + 32'h10, 1'b1, 4'hF, 32'h0));
    vecs.push_back(one(1, B + 32'h20, 1'b0, 4'hF, 32'h1122_3344));
    vecs.push_back(one(1, B + 32'h20, 1'b0, 4'h5, 32'hAABB_CCDD));
    vecs.push_back(one(1, B + 32'h20, 1'b1, 4'hF, 32'h0));
    vecs.push_back(one(2, B + 32'h00, 1'b0, 4'hF, 32'h5A5A_5A5A));
    for (int i = 0; i < 6; i++) begin
      v = '0;
      for (int p = 0; p < 3; p++) v = addPort(v, p, B, 1'b1, 4'hF, 32'h0);
      v.expGnt = 3'b001 << (i % 3);
      vecs.push_back(v);
    end
    v = '0;
    v = addPort(v, 0, B + 32'h4, 1'b0, 4'hF, 32'h0102_0304);
    v = addPort(v, 1, B + 32'h8, 1'b0, 4'hF, 32'h0A0B_0C0D);
    v = addPort(v, 2, B + 32'hC, 1'b0, 4'hF, 32'h0F0E_0D0C);
    v.expGnt = 3'b111;
    vecs.push_back(v);
    v = '0;
    v = addPort(v, 0, B + 32'h0, 1'b1, 4'hF, 32'h0);
    v = addPort(v, 1, B + 32'h4, 1'b1, 4'hF, 32'h0);
    v = addPort(v, 2, B + 32'h8, 1'b1, 4'hF, 32'h0);
    v.expGnt = 3'b111;
    vecs.push_back(v);
    v = '0;
    v = addPort(v, 0, B + 32'h4, 1'b1, 4'hF, 32'h0);
    v = addPort(v, 1, B + 32'hC, 1'b1, 4'hF, 32'h0);
    v = addPort(v, 2, B + 32'h4, 1'b1, 4'hF, 32'h0);
    v.expGnt = 3'b110;
    vecs.push_back(v);
    vecs.push_back(one(0, B + 32'h4, 1'b1, 4'hF, 32'h0));
    vecs.push_back(one(0, B + 32'h10, 1'b0, 4'h0, 32'hFFFF_FFFF));
    vecs.push_back(one(0, B + 32'h10, 1'b1, 4'hF, 32'h0));
    vecs.push_back(one(1, B + 32'h4000, 1'b1, 4'hF, 32'h0));
    vecs.push_back(one(2, B - 32'h4, 1'b0, 4'hF, 32'h1234_5678));
    v = '0;
    v = addPort(v, 0, B + 32'h4010, 1'b1, 4'hF, 32'h0);
    v = addPort(v, 1, B + 32'h10, 1'b1, 4'hF, 32'h0);
    v.expGnt = 3'b011;
    vecs.push_back(v);
    vecs.push_back('0);
    vecs.push_back(one(2, B + 32'hC, 1'b0, 4'h8, 32'h99FF_FFFF));
    vecs.push_back(one(1, B + 32'hC, 1'b1, 4'hF, 32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
      if (i == 11) checkOutput("rotate/cnt", 96'(cnt), 96'(12));
    end

    // Reset while port 0 has a granted read waiting for its response
    req             = 3'b001;
    add[31:0]       = B + 32'h20;
    typ[0]          = 1'b1;
    be[3:0]         = 4'hF;
    @(negedge clk);
    checkOutput("rstseq/gnt", 96'(gnt), 96'(3'b001));
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rstseq/flush", 96'(rvalid), 96'(0));
    checkOutput("rstseq/gntMask", 96'(gnt), 96'(0));
    checkOutput("rstseq/cnt", 96'(cnt), 96'(0));
    checkOutput("rstseq/err", 96'(err), 96'(0));
    @(posedge clk);
    #1;
    rst  = 1'b0;
    req  = '0;
    sb.delete();
    mCnt = '0;
    mErr = 1'b0;
    for (int p = 0; p < 3; p++) lastData[p] = '0;

    applyStimulus('0, "post/idle");
    v = '0;
    for (int p = 0; p < 3; p++) v = addPort(v, p, B, 1'b1, 4'hF, 32'h0);
    v.expGnt = 3'b001;
    applyStimulus(v, "post/arbRestart");
    applyStimulus(one(0, B + 32'h20, 1'b1, 4'hF, 32'h0), "post/retained");
    checkOutput("post/retainedConst", 96'(rdata[31:0]), 96'(32'h11BB_33DD));

    $display("== %0d vectors applied, %0d miscompares ==", compCount, failCount);
    $finish;
  end

endmodule
